// File: rtl/dcache_writeback_buffer_if.sv
// dcache_writeback_buffer_if: push, lookup and drain signals of the dcache writeback buffer.
// slave is the buffer side, master is the dcache / AXI slave side.
interface dcache_writeback_buffer_if #(
   parameter int DEPTH      = 4,
   parameter int LINE_WORDS = 4
);
   localparam int LINE_BITS = 32 * LINE_WORDS;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic                 up_wr_req;
   logic [31:0]          up_wr_addr;
   logic [LINE_BITS-1:0] up_wr_data;
   logic                 up_wr_rdy;
   logic [31:0]          lk_addr;
   logic                 lk_hit;
   logic [LINE_BITS-1:0] lk_data;
   logic                 dn_wr_req;
   logic [31:0]          dn_wr_addr;
   logic [LINE_BITS-1:0] dn_wr_data;
   logic                 dn_wr_rdy;
   logic                 dn_wr_valid;
   logic                 wb_empty;
   logic [CNT_W-1:0]     wb_count;

   modport slave (
      input  up_wr_req, up_wr_addr, up_wr_data,
      input  lk_addr, dn_wr_rdy, dn_wr_valid,
      output up_wr_rdy, lk_hit, lk_data,
      output dn_wr_req, dn_wr_addr, dn_wr_data,
      output wb_empty, wb_count
   );

   modport master (
      output up_wr_req, up_wr_addr, up_wr_data,
      output lk_addr, dn_wr_rdy, dn_wr_valid,
      input  up_wr_rdy, lk_hit, lk_data,
      input  dn_wr_req, dn_wr_addr, dn_wr_data,
      input  wb_empty, wb_count
   );
endinterface

// File: rtl/dcache_writeback_buffer.sv
// dcache_writeback_buffer: FIFO of evicted dirty lines drained to the AXI line-write slave,
// with a lookup port forwarding buffered lines; DCACHE_WB_MERGE_EN enables in-place merging.
module dcache_writeback_buffer #(
   parameter int DEPTH      = 4,
   parameter int LINE_WORDS = 4
) (
   input logic                      clk,
   input logic                      resetn,
   dcache_writeback_buffer_if.slave bus
);
   localparam int LINE_BITS = 32 * LINE_WORDS;
   localparam int OFF_W     = $clog2(LINE_WORDS * 4);
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int CNT_W     = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} st_e;

   st_e                  st_q, st_d;
   logic [31:0]          addr_q [DEPTH];
   logic [LINE_BITS-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]     vld_q, vld_d;
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 full, push, app, pop;
   logic                 mrg_hit;
   logic [PTR_W-1:0]     mrg_idx;
   logic                 lk_hit;
   logic [LINE_BITS-1:0] lk_data;
   logic [PTR_W-1:0]     lk_idx;
   logic [31:0]          up_line;
   logic                 unused_lo;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign up_line = {bus.up_wr_addr[31:OFF_W], {OFF_W{1'b0}}};
   assign push    = bus.up_wr_req & bus.up_wr_rdy;
   assign app     = push & ~mrg_hit;

   assign bus.up_wr_rdy  = ~full | mrg_hit;
   assign bus.wb_empty   = (cnt_q == '0);
   assign bus.wb_count   = cnt_q;
   assign bus.dn_wr_req  = (st_q == S_REQ);
   assign bus.dn_wr_addr = addr_q[head_q];
   assign bus.dn_wr_data = data_q[head_q];
   assign bus.lk_hit     = lk_hit;
   assign bus.lk_data    = lk_data;

   assign unused_lo = ^{bus.lk_addr[OFF_W-1:0], bus.up_wr_addr[OFF_W-1:0]};

`ifdef DCACHE_WB_MERGE_EN
   logic [PTR_W-1:0] mg_idx;

   // the head is off limits once its write has been issued
   always_comb begin
      mrg_hit = 1'b0;
      mrg_idx = '0;
      mg_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         mg_idx = head_q + PTR_W'(k);
         if (vld_q[mg_idx] &&
             addr_q[mg_idx][31:OFF_W] == bus.up_wr_addr[31:OFF_W] &&
             !(k == 0 && st_q != S_IDLE)) begin
            mrg_hit = 1'b1;
            mrg_idx = mg_idx;
         end
      end
   end
`else
   assign mrg_hit = 1'b0;
   assign mrg_idx = '0;
`endif

   // oldest to youngest, so the last match is the youngest
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = '0;
      lk_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         lk_idx = head_q + PTR_W'(k);
         if (vld_q[lk_idx] &&
             addr_q[lk_idx][31:OFF_W] == bus.lk_addr[31:OFF_W]) begin
            lk_hit  = 1'b1;
            lk_data = data_q[lk_idx];
         end
      end
   end

   always_comb begin
      st_d = st_q;
      pop  = 1'b0;
      unique case (st_q)
         S_IDLE: if (cnt_q != '0 || app) st_d = S_REQ;
         S_REQ:  if (bus.dn_wr_rdy) st_d = S_WAIT;
         S_WAIT: begin
            if (bus.dn_wr_valid) begin
               pop  = 1'b1;
               st_d = S_IDLE;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_comb begin
      vld_d = vld_q;
      if (app) vld_d[tail_q] = 1'b1;
      if (pop) vld_d[head_q] = 1'b0;
      tail_d = app ? tail_q + PTR_W'(1) : tail_q;
      head_d = pop ? head_q + PTR_W'(1) : head_q;
      cnt_d  = cnt_q + CNT_W'(app) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         st_q   <= S_IDLE;
         vld_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         st_q   <= st_d;
         vld_q  <= vld_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         if (mrg_hit) begin
            data_q[mrg_idx] <= bus.up_wr_data;
         end else begin
            addr_q[tail_q] <= up_line;
            data_q[tail_q] <= bus.up_wr_data;
         end
      end
   end
endmodule
